// File: rtl/plate_locate.sv
// Plate locator: row-projection over a binarised stream. Qualifying rows form
// runs; the tallest run of a frame gives up/down, and its white x-extent gives
// left/right. Results of frame N are presented at the start of frame N+1.
module plate_locate #(
  parameter logic [9:0] ROW_TH    = 10'd20,
  parameter logic [9:0] MIN_H     = 10'd10,
  parameter logic [9:0] MIN_W     = 10'd40,
  parameter logic [3:0] MIN_RATIO = 4'd2,
  parameter logic [3:0] MAX_RATIO = 4'd6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic       per_frame_bit,
  output logic [9:0] plate_boarder_up,
  output logic [9:0] plate_boarder_down,
  output logic [9:0] plate_boarder_left,
  output logic [9:0] plate_boarder_right,
  output logic       plate_exist_flag,
  output logic       plate_valid
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  localparam logic [9:0] SAT = 10'd1023;

  logic       vsync_q, href_q;
  logic [9:0] x_q, y_q, rcnt_q, rmin_q, rmax_q;
  logic       run_q;
  logic [9:0] cu_q, cd_q, cl_q, cr_q;
  logic [9:0] bu_q, bd_q, bl_q, br_q;
  logic       bv_q, seen_q;

  logic vsync_pos, href_neg, acc, row_ok;
  assign vsync_pos = per_frame_vsync & ~vsync_q;
  assign href_neg  = ~per_frame_href & href_q;
  assign acc       = per_frame_clken & per_frame_href;
  assign row_ok    = (rcnt_q >= ROW_TH);

  // Row-end step (st1/*1) followed by the frame-end close (*2), so a row ending
  // in the same cycle as the frame boundary is folded in before the latch.
  logic       st1, bv1, bv2;
  logic [9:0] cu1, cd1, cl1, cr1, bu1, bd1, bl1, br1, bu2, bd2, bl2, br2;
  always_comb begin
    st1 = run_q;
    cu1 = cu_q; cd1 = cd_q; cl1 = cl_q; cr1 = cr_q;
    bu1 = bu_q; bd1 = bd_q; bl1 = bl_q; br1 = br_q; bv1 = bv_q;
    if (href_neg) begin
      if (row_ok) begin
        if (run_q == IDLE) begin
          st1 = RUN;
          cu1 = y_q; cd1 = y_q; cl1 = rmin_q; cr1 = rmax_q;
        end else begin
          cd1 = y_q;
          cl1 = (rmin_q < cl_q) ? rmin_q : cl_q;
          cr1 = (rmax_q > cr_q) ? rmax_q : cr_q;
        end
      end else if (run_q == RUN) begin
        st1 = IDLE;
        // strict compare: on equal height the earlier run is kept
        if (!bv_q || ((cd_q - cu_q) > (bd_q - bu_q))) begin
          bu1 = cu_q; bd1 = cd_q; bl1 = cl_q; br1 = cr_q; bv1 = 1'b1;
        end
      end
    end
    bu2 = bu1; bd2 = bd1; bl2 = bl1; br2 = br1; bv2 = bv1;
    if (st1 == RUN && (!bv1 || ((cd1 - cu1) > (bd1 - bu1)))) begin
      bu2 = cu1; bd2 = cd1; bl2 = cl1; br2 = cr1; bv2 = 1'b1;
    end
  end

  // Size and aspect checks on the frame-end candidate; 14-bit products cannot overflow.
  logic [9:0]  h, w;
  logic [13:0] w14, lo14, hi14;
  logic        exist;
  always_comb begin
    h     = bd2 - bu2 + 10'd1;
    w     = br2 - bl2 + 10'd1;
    w14   = {4'd0, w};
    lo14  = {4'd0, h} * {10'd0, MIN_RATIO};
    hi14  = {4'd0, h} * {10'd0, MAX_RATIO};
    exist = bv2 & (h >= MIN_H) & (w >= MIN_W) & (w14 >= lo14) & (w14 <= hi14);
  end

  // Input sync and pixel/line counters. vsync_q resets high so a reset released
  // mid-frame is not mistaken for a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      if (href_neg || vsync_pos) x_q <= '0;
      else if (acc && x_q != SAT) x_q <= x_q + 10'd1;
      if (vsync_pos) y_q <= '0;
      else if (href_neg && y_q != SAT) y_q <= y_q + 10'd1;
    end
  end

  // Per-row white count and x-extent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      rmin_q <= SAT;
      rmax_q <= '0;
    end else if (href_neg || vsync_pos) begin
      rcnt_q <= '0;
      rmin_q <= SAT;
      rmax_q <= '0;
    end else if (acc && per_frame_bit) begin
      if (rcnt_q != SAT) rcnt_q <= rcnt_q + 10'd1;
      if (x_q < rmin_q) rmin_q <= x_q;
      if (x_q > rmax_q) rmax_q <= x_q;
    end
  end

  // Run tracker and best-run holder; cleared at every frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= IDLE;
      {cu_q, cd_q, cl_q, cr_q} <= '0;
      {bu_q, bd_q, bl_q, br_q} <= '0;
      bv_q   <= 1'b0;
      seen_q <= 1'b0;
    end else if (vsync_pos) begin
      run_q <= IDLE;
      {cu_q, cd_q, cl_q, cr_q} <= '0;
      {bu_q, bd_q, bl_q, br_q} <= '0;
      bv_q   <= 1'b0;
      seen_q <= 1'b1;
    end else begin
      run_q <= st1;
      {cu_q, cd_q, cl_q, cr_q} <= {cu1, cd1, cl1, cr1};
      {bu_q, bd_q, bl_q, br_q} <= {bu1, bd1, bl1, br1};
      bv_q <= bv1;
    end
  end

  // Result latch at frame start, skipped when no complete frame has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plate_boarder_up    <= '0;
      plate_boarder_down  <= '0;
      plate_boarder_left  <= '0;
      plate_boarder_right <= '0;
      plate_exist_flag    <= 1'b0;
      plate_valid         <= 1'b0;
    end else if (vsync_pos && seen_q) begin
      plate_boarder_up    <= bv2 ? bu2 : 10'd0;
      plate_boarder_down  <= bv2 ? bd2 : 10'd0;
      plate_boarder_left  <= bv2 ? bl2 : 10'd0;
      plate_boarder_right <= bv2 ? br2 : 10'd0;
      plate_exist_flag    <= exist;
      plate_valid         <= 1'b1;
    end else begin
      plate_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plate_locate.sv
// Directed bench for plate_locate: synthetic frames of white bands, expected
// boxes worked out by hand from the band geometry.
module tb_plate_locate;
  logic clk = 1'b0, rst_n = 1'b0;
  logic vs = 1'b0, hr = 1'b0, ce = 1'b0, bt = 1'b0;
  logic [9:0] up, dn, lf, rt;
  logic ex, pv;
  int n_chk = 0, n_pass = 0, pv_cnt = 0;

  always #5 clk = ~clk;

  plate_locate dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr),
    .per_frame_clken(ce), .per_frame_bit(bt),
    .plate_boarder_up(up), .plate_boarder_down(dn),
    .plate_boarder_left(lf), .plate_boarder_right(rt),
    .plate_exist_flag(ex), .plate_valid(pv)
  );

  always @(negedge clk) if (pv) pv_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One line of n pixels, white where x0 <= x <= x1; n=0 gives an empty line.
  task automatic line(input int n, input int x0, input int x1);
    @(negedge clk);
    if (n == 0) begin
      hr = 1'b1; @(negedge clk);
    end else begin
      for (int x = 0; x < n; x++) begin
        hr = 1'b1; ce = 1'b1; bt = (x >= x0 && x <= x1);
        @(negedge clk);
      end
    end
    hr = 1'b0; ce = 1'b0; bt = 1'b0;
    @(negedge clk);
  endtask

  // Frame body with up to two white bands (rows u..d, columns l..r).
  task automatic bands(input int rows, input int len,
                       input int u0, input int d0, input int l0, input int r0,
                       input int u1, input int d1, input int l1, input int r1);
    for (int y = 0; y < rows; y++) begin
      if (y >= u0 && y <= d0)      line(len, l0, r0);
      else if (y >= u1 && y <= d1) line(len, l1, r1);
      else                         line(0, 0, 0);
    end
  endtask

  // Frame boundary: vsync low then high; checks the pulse count and the box.
  task automatic next_frame(input string tag, input int epv, input int eu,
                            input int ed, input int el, input int er, input int ee);
    int p0;
    p0 = pv_cnt;
    @(negedge clk); vs = 1'b0;
    repeat (3) @(negedge clk);
    vs = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, ".pv"}, pv_cnt - p0, epv);
    if (epv != 0) begin
      chk({tag, ".up"}, up, eu);
      chk({tag, ".down"}, dn, ed);
      chk({tag, ".left"}, lf, el);
      chk({tag, ".right"}, rt, er);
      chk({tag, ".exist"}, ex, ee);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.up", up, 0); chk("rst.down", dn, 0); chk("rst.left", lf, 0);
    chk("rst.right", rt, 0); chk("rst.exist", ex, 0); chk("rst.pv", pv, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    next_frame("first", 0, 0, 0, 0, 0, 0);
    bands(480, 0, -1, -1, 0, 0, -1, -1, 0, 0);
    next_frame("zero1", 1, 0, 0, 0, 0, 0);
    bands(480, 0, -1, -1, 0, 0, -1, -1, 0, 0);
    next_frame("zero2", 1, 0, 0, 0, 0, 0);

    bands(160, 360, 100, 149, 200, 359, -1, -1, 0, 0);
    next_frame("rect", 1, 100, 149, 200, 359, 1);

    bands(345, 300, 50, 59, 100, 299, 300, 339, 100, 299);
    next_frame("tall", 1, 300, 339, 100, 299, 1);

    bands(85, 180, 10, 29, 0, 59, 60, 79, 100, 179);
    next_frame("tie", 1, 10, 29, 0, 59, 1);

    // rows 50..89 carry 19 whites each: taller than the square, must not qualify
    bands(95, 40, 10, 39, 10, 39, 50, 89, 0, 18);
    next_frame("small", 1, 10, 39, 10, 39, 0);

    // w=61 exceeds h*6=60
    bands(12, 61, 0, 9, 0, 60, -1, -1, 0, 0);
    next_frame("ratio", 1, 0, 9, 0, 60, 0);

    // run still open when the frame ends
    bands(480, 200, 440, 479, 0, 199, -1, -1, 0, 0);
    next_frame("last", 1, 440, 479, 0, 199, 1);

    // reset while a run is open
    bands(20, 100, 0, 19, 0, 99, -1, -1, 0, 0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid.up", up, 0); chk("mid.down", dn, 0); chk("mid.right", rt, 0);
    chk("mid.exist", ex, 0);
    @(negedge clk); rst_n = 1'b1;
    bands(5, 0, -1, -1, 0, 0, -1, -1, 0, 0);
    next_frame("afterrst", 0, 0, 0, 0, 0, 0);
    bands(45, 100, 20, 39, 0, 99, -1, -1, 0, 0);
    next_frame("recover", 1, 20, 39, 0, 99, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
